// File: rtl/varint_field_arbiter_pkg.sv
// Shared definitions for the varint field arbiter: wire type, key layout and FSM encodings.
package varint_pkg;

  localparam logic [2:0] WIRE_TYPE_VARINT = 3'd0;
  localparam int         KEY_SHIFT        = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_KEY  = 3'b010,
    ST_VAL  = 3'b100
  } state_t;

  // Protobuf key word: field number above the 3-bit wire type, zero-extended to 32 bits.
  function automatic logic [31:0] make_key(input logic [28:0] field_num);
    return (32'(field_num) << KEY_SHIFT) | 32'(WIRE_TYPE_VARINT);
  endfunction

endpackage

// File: rtl/varint_field_arbiter_rr_arbiter.sv
// Combinational rotating-priority pick: first requester at or after last+1, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     any_req
);

  localparam int IDX_W = $clog2(N_REQ);

  always_comb begin
    int idx;
    idx     = 0;
    gnt_idx = '0;
    any_req = |req;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) gnt_idx = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/varint_field_arbiter.sv
// Round-robin sharing of one varint encoder input FIFO: each grant emits an atomic key/value pair.
module varint_field_arbiter
  import varint_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int FIELD_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_REQ-1:0]           req_fifo_empty,
  output logic [N_REQ-1:0]           req_fifo_pop,
  input  logic [N_REQ*32-1:0]        req_data,
  input  logic [N_REQ*FIELD_W-1:0]   req_field_num,
  input  logic                       enc_fifo_full,
  output logic                       enc_fifo_push,
  output logic [31:0]                enc_data,
  output logic                       enc_is_value,
  output logic                       grant_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [CNT_W-1:0]           pair_count
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [FIELD_W-1:0] field_num_q, field_num_d;
  logic [CNT_W-1:0]   pair_count_q, pair_count_d;

  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req     (~req_fifo_empty),
    .last    (last_grant_q),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    field_num_d   = field_num_q;
    pair_count_d  = pair_count_q;
    req_fifo_pop  = '0;
    enc_fifo_push = 1'b0;
    enc_data      = '0;
    enc_is_value  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && arb_any) begin
          grant_id_d  = arb_idx;
          field_num_d = req_field_num[int'(arb_idx)*FIELD_W +: FIELD_W];
          state_d     = ST_KEY;
        end
      end
      ST_KEY: begin
        enc_data = make_key(29'(field_num_q));
        if (!enc_fifo_full) begin
          enc_fifo_push = 1'b1;
          state_d       = ST_VAL;
        end
      end
      ST_VAL: begin
        enc_data     = req_data[int'(grant_id_q)*32 +: 32];
        enc_is_value = 1'b1;
        if (!enc_fifo_full) begin
          enc_fifo_push            = 1'b1;
          req_fifo_pop[grant_id_q] = 1'b1;
          last_grant_d             = grant_id_q;
          pair_count_d             = pair_count_q + CNT_W'(1);
          state_d                  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset cycle must not leak a push or pop from the interrupted pair.
    if (reset) begin
      req_fifo_pop  = '0;
      enc_fifo_push = 1'b0;
      enc_data      = '0;
      enc_is_value  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      field_num_q  <= '0;
      pair_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      field_num_q  <= field_num_d;
      pair_count_q <= pair_count_d;
    end
  end

  assign grant_valid = !reset && ((state_q == ST_KEY) || (state_q == ST_VAL));
  assign grant_id    = grant_id_q;
  assign pair_count  = pair_count_q;

endmodule

// File: tb/tb_varint_field_arbiter.sv
// Directed bench for varint_field_arbiter: FWFT requester FIFO models plus push/pop logging.
module tb_varint_field_arbiter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  req_fifo_empty;
  logic [3:0]  req_fifo_pop;
  logic [127:0] req_data;
  logic [19:0] req_field_num;
  logic        enc_fifo_full;
  logic        enc_fifo_push;
  logic [31:0] enc_data;
  logic        enc_is_value;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [3:0]  pair_count;

  varint_field_arbiter #(.N_REQ(4), .FIELD_W(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_fifo_empty(req_fifo_empty), .req_fifo_pop(req_fifo_pop),
    .req_data(req_data), .req_field_num(req_field_num),
    .enc_fifo_full(enc_fifo_full), .enc_fifo_push(enc_fifo_push),
    .enc_data(enc_data), .enc_is_value(enc_is_value),
    .grant_valid(grant_valid), .grant_id(grant_id), .pair_count(pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester FIFOs: mem/wr_ptr written by stimulus, rd_ptr advanced by DUT pops.
  logic [31:0] mem [4][64];
  logic [5:0]  wr_ptr [4] = '{default: 6'd0};
  logic [5:0]  rd_ptr [4] = '{default: 6'd0};
  logic [4:0]  field_num [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
    assign req_fifo_empty[gi]        = (rd_ptr[gi] == wr_ptr[gi]);
    assign req_data[32*gi +: 32]     = mem[gi][rd_ptr[gi]];
    assign req_field_num[5*gi +: 5]  = field_num[gi];
  end

  int          cyc = 0;
  int          log_n = 0;
  int          pop_n = 0;
  int          viol = 0;
  logic [31:0] log_data [256];
  logic        log_val  [256];
  int          log_cyc  [256];
  int          pop_id   [256];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (enc_fifo_push) begin
      log_data[log_n] <= enc_data;
      log_val[log_n]  <= enc_is_value;
      log_cyc[log_n]  <= cyc;
      log_n           <= log_n + 1;
    end
    if ((enc_fifo_push && enc_fifo_full) || (|req_fifo_pop && !enc_fifo_push) ||
        ($countones(req_fifo_pop) > 1))
      viol <= viol + 1;
    for (int i = 0; i < 4; i++) begin
      if (req_fifo_pop[i]) begin
        rd_ptr[i]     <= rd_ptr[i] + 6'd1;
        pop_id[pop_n] <= i;
      end
    end
    if (|req_fifo_pop) pop_n <= pop_n + 1;
  end

  int checks = 0;
  int passes = 0;

  task automatic load(input int r, input logic [31:0] w);
    mem[r][wr_ptr[r]] = w;
    wr_ptr[r] = wr_ptr[r] + 6'd1;
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (grant_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pops(input int target, input int budget, output bit ok);
    ok = (pop_n >= target);
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (pop_n >= target);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; enc_fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) field_num[i] = 5'(i + 1);
    repeat (3) @(negedge clk);
    checks++; if (enc_fifo_push !== 1'b0) $display("FAIL reset_push got %b exp 0", enc_fifo_push); else passes++;
    checks++; if (req_fifo_pop !== 4'b0) $display("FAIL reset_pop got %b exp 0000", req_fifo_pop); else passes++;
    checks++; if (enc_data !== 32'h0) $display("FAIL reset_data got %h exp 0", enc_data); else passes++;
    checks++; if (grant_valid !== 1'b0) $display("FAIL reset_gvalid got %b exp 0", grant_valid); else passes++;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (grant_id !== 2'd0) $display("FAIL reset_gid got %0d exp 0", grant_id); else passes++;
    checks++; if (pair_count !== 4'd0) $display("FAIL reset_count got %0d exp 0", pair_count); else passes++;
    $display("test_reset done");
  endtask

  task automatic test_single;
    int s, ps, c0;
    bit ok;
    s = log_n; ps = pop_n; c0 = cyc;
    enable = 1'b1;
    load(0, 32'h0000_012C);
    wait_pops(ps + 1, 10, ok);
    @(negedge clk);
    checks++; if (!ok) $display("FAIL single_timeout pops %0d exp %0d", pop_n - ps, 1); else passes++;
    checks++; if (log_n - s !== 2) $display("FAIL single_pushes got %0d exp 2", log_n - s); else passes++;
    checks++; if (log_data[s] !== 32'h0000_0008 || log_val[s] !== 1'b0)
      $display("FAIL single_key got %h/%b exp 00000008/0", log_data[s], log_val[s]); else passes++;
    checks++; if (log_data[s+1] !== 32'h0000_012C || log_val[s+1] !== 1'b1)
      $display("FAIL single_val got %h/%b exp 0000012c/1", log_data[s+1], log_val[s+1]); else passes++;
    checks++; if (log_cyc[s] !== c0 + 1 || log_cyc[s+1] !== c0 + 2)
      $display("FAIL single_latency got %0d,%0d exp %0d,%0d", log_cyc[s], log_cyc[s+1], c0 + 1, c0 + 2); else passes++;
    checks++; if (pop_n - ps !== 1 || pop_id[ps] !== 0)
      $display("FAIL single_pop got n=%0d id=%0d exp n=1 id=0", pop_n - ps, pop_id[ps]); else passes++;
    checks++; if (pair_count !== 4'd1) $display("FAIL single_count got %0d exp 1", pair_count); else passes++;
    $display("test_single done: key %h value %h", log_data[s], log_data[s+1]);
  endtask

  task automatic test_round_robin;
    int s, ps, bad;
    bit ok;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    s = log_n; ps = pop_n;
    for (int w = 0; w < 2; w++)
      for (int r = 0; r < 4; r++) load(r, 32'h1000_0000 | 32'(r << 4) | 32'(w));
    wait_pops(ps + 8, 40, ok);
    @(negedge clk);
    checks++; if (!ok) $display("FAIL rr_timeout pops %0d exp 8", pop_n - ps); else passes++;
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (pop_id[ps+p] !== p % 4 || log_data[s+2*p] !== 32'((p % 4 + 1) << 3) ||
          log_data[s+2*p+1] !== (32'h1000_0000 | 32'((p % 4) << 4) | 32'(p / 4)))
        $display("FAIL rr_pair%0d got id=%0d key=%h val=%h exp id=%0d", p, pop_id[ps+p],
                 log_data[s+2*p], log_data[s+2*p+1], p % 4);
      else passes++;
    end
    bad = 0;
    for (int p = 0; p < 7; p++) if (log_cyc[s+2*p+2] - log_cyc[s+2*p] != 3) bad++;
    checks++; if (bad !== 0) $display("FAIL rr_throughput got %0d gaps not 3 exp 0", bad); else passes++;
    checks++; if (pair_count !== 4'd8) $display("FAIL rr_count got %0d exp 8", pair_count); else passes++;
    $display("test_round_robin done: %0d pairs", pop_n - ps);
  endtask

  task automatic test_backpressure;
    int s, ps;
    bit ok;
    s = log_n; ps = pop_n;
    load(2, 32'hDEAD_BEEF);
    wait_grant(10, ok);
    checks++; if (!ok || grant_id !== 2'd2) $display("FAIL bp_grant got ok=%b id=%0d exp id=2", ok, grant_id); else passes++;
    enc_fifo_full = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (log_n !== s || enc_is_value !== 1'b0 || grant_valid !== 1'b1)
      $display("FAIL bp_key_hold got pushes=%0d isval=%b exp 0/0", log_n - s, enc_is_value); else passes++;
    enc_fifo_full = 1'b0;
    @(negedge clk);
    checks++; if (log_n !== s + 1 || log_data[s] !== 32'h18)
      $display("FAIL bp_key got n=%0d data=%h exp 1/00000018", log_n - s, log_data[s]); else passes++;
    enc_fifo_full = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (log_n !== s + 1 || pop_n !== ps || enc_is_value !== 1'b1)
      $display("FAIL bp_val_hold got pushes=%0d pops=%0d exp 1/0", log_n - s, pop_n - ps); else passes++;
    enc_fifo_full = 1'b0;
    @(negedge clk);
    checks++; if (log_n !== s + 2 || log_data[s+1] !== 32'hDEAD_BEEF || pop_n !== ps + 1 || pop_id[ps] !== 2)
      $display("FAIL bp_val got n=%0d data=%h pops=%0d exp 2/deadbeef/1", log_n - s, log_data[s+1], pop_n - ps); else passes++;
    $display("test_backpressure done: value %h", log_data[s+1]);
  endtask

  task automatic test_enable;
    int s, ps;
    bit ok;
    s = log_n; ps = pop_n;
    load(0, 32'h0000_00A0);
    load(1, 32'h0000_00B1);
    wait_grant(10, ok);
    checks++; if (!ok || grant_id !== 2'd0) $display("FAIL en_grant got ok=%b id=%0d exp id=0", ok, grant_id); else passes++;
    enable = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (log_n - s !== 2 || pop_n - ps !== 1 || pop_id[ps] !== 0 || grant_valid !== 1'b0)
      $display("FAIL en_hold got pushes=%0d pops=%0d gv=%b exp 2/1/0", log_n - s, pop_n - ps, grant_valid); else passes++;
    enable = 1'b1;
    wait_pops(ps + 2, 10, ok);
    @(negedge clk);
    checks++; if (!ok || pop_id[ps+1] !== 1 || log_data[s+2] !== 32'h10 || log_data[s+3] !== 32'hB1)
      $display("FAIL en_resume got ok=%b id=%0d key=%h val=%h exp id=1 key=10 val=b1",
               ok, pop_id[ps+1], log_data[s+2], log_data[s+3]); else passes++;
    $display("test_enable done");
  endtask

  task automatic test_reset_mid_pair;
    int s, ps;
    bit ok;
    s = log_n; ps = pop_n;
    load(2, 32'h0000_00C2);
    load(0, 32'h0000_00C0);
    wait_grant(10, ok);
    checks++; if (!ok || grant_id !== 2'd2) $display("FAIL rst_grant got ok=%b id=%0d exp id=2", ok, grant_id); else passes++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (grant_valid !== 1'b0 || pair_count !== 4'd0 || pop_n !== ps)
      $display("FAIL rst_idle got gv=%b cnt=%0d pops=%0d exp 0/0/0", grant_valid, pair_count, pop_n - ps); else passes++;
    reset = 1'b0;
    wait_pops(ps + 2, 15, ok);
    @(negedge clk);
    checks++; if (!ok || pop_id[ps] !== 0 || pop_id[ps+1] !== 2)
      $display("FAIL rst_order got ok=%b ids=%0d,%0d exp 0,2", ok, pop_id[ps], pop_id[ps+1]); else passes++;
    checks++; if (log_n - s !== 5 || log_data[s+4] !== 32'hC2 || pair_count !== 4'd2)
      $display("FAIL rst_words got n=%0d last=%h cnt=%0d exp 5/c2/2", log_n - s, log_data[s+4], pair_count); else passes++;
    $display("test_reset_mid_pair done");
  endtask

  task automatic test_wrap;
    int s, ps, bad;
    bit ok;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    field_num[0] = 5'd31;
    s = log_n; ps = pop_n;
    for (int k = 0; k < 17; k++) load(0, 32'h100 + 32'(k));
    wait_pops(ps + 17, 80, ok);
    @(negedge clk);
    checks++; if (!ok) $display("FAIL wrap_timeout pops %0d exp 17", pop_n - ps); else passes++;
    checks++; if (pair_count !== 4'd1) $display("FAIL wrap_count got %0d exp 1", pair_count); else passes++;
    checks++; if (log_data[s] !== 32'h0000_00F8) $display("FAIL wrap_key got %h exp 000000f8", log_data[s]); else passes++;
    bad = 0;
    for (int k = 0; k < 17; k++)
      if (log_data[s+2*k] !== 32'hF8 || log_data[s+2*k+1] !== 32'h100 + 32'(k) || pop_id[ps+k] !== 0) bad++;
    checks++; if (bad !== 0) $display("FAIL wrap_pairs got %0d bad pairs exp 0", bad); else passes++;
    $display("test_wrap done: pair_count %0d", pair_count);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; enc_fifo_full = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_enable;
    test_reset_mid_pair;
    test_wrap;
    checks++; if (viol !== 0) $display("FAIL protocol got %0d violations exp 0", viol); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
